power_spectrum: RTL and testbench
=================================

Name: power_spectrum

Overview:
- Stage directly upstream of the log stage in the log-mel pipeline.
- Consumes the complex FFT output stream, N_FFT bins per frame in natural order.
- Keeps only the N_BIN non-redundant bins (0..N_FFT/2) of each frame and computes power = re² + im², scaled and saturated to O_BW.
- Emits each power value with the bin index, frame number and first/last tags the log stage expects.

Parameters:
I_BW, 16, signed width of FFT real/imag inputs
O_BW, 14, signed width of power output (value always non-negative)
N_FFT, 1024, FFT points per frame
N_BIN, 513, bins kept per frame (N_FFT/2+1)
N_FRAME, 89, frames per utterance
SHIFT, 17, right shift applied to the 2*I_BW-bit power before saturation

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
data_re_i  input  I_BW  signed FFT real part
data_im_i  input  I_BW  signed FFT imaginary part
di_en  input  1  input valid, one bin per asserted cycle
data_o  output  O_BW  signed power value (>= 0)
do_en  output  1  output valid
out_group_idx  output  10  bin index 0..N_BIN-1
out_group_num  output  7  frame number 0..N_FRAME-1
is_first_out  output  1  high with bin 0 of a frame
is_last_out  output  1  high with bin N_BIN-1 of a frame
all_done  output  1  one-cycle pulse with the last bin of frame N_FRAME-1

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low: rst low clears all state immediately.
- Reset values: all outputs 0, bin counter 0, frame counter 0, pipeline valid bits 0.
- Bin counter (0..N_FFT-1):
  - Increments on every cycle with di_en=1.
  - Wraps from N_FFT-1 to 0; on that wrap the frame counter increments.
- Frame counter:
  - Wraps from N_FRAME-1 to 0 with no stall; the next utterance starts seamlessly.
- Bin filter: an input is forwarded only when the bin counter < N_BIN. Bins N_BIN..N_FFT-1 still advance the counter but never produce do_en.
- Stage 1 (registered on an accepted input):
  - sq_re = re*re and sq_im = im*im, each signed×signed into 2*I_BW bits.
  - Bin index, frame number and first/last flags captured alongside.
  - v1 = accepted.
- Stage 2 (registered):
  - sum = sq_re + sq_im, unsigned, 2*I_BW bits. Worst case 2^31 at I_BW=16; no overflow, the width is exact.
  - p = sum >> SHIFT (truncate).
  - data_o = min(p, 2^(O_BW-1)-1). Default saturation value is 8191.
  - do_en = v1; sideband signals copied from stage 1.
- Latency: exactly 2 cycles from an accepted di_en edge to do_en. Throughput is 1 per cycle.
- Bubbles:
  - Gaps in di_en propagate as do_en=0 gaps.
  - No backpressure; the pipeline advances every cycle.
- Output hold: when do_en=0, data_o and the sideband signals hold their last values. Consumers qualify by do_en only.
- Tags:
  - is_first_out=1 iff out_group_idx==0.
  - is_last_out=1 iff out_group_idx==N_BIN-1.
  - all_done=1 iff is_last_out && out_group_num==N_FRAME-1 && do_en.
- Reset mid-frame: in-flight pipeline results are discarded (no do_en after reset release). The counters restart, so the next di_en is bin 0 of frame 0.
- di_en asserted during reset: ignored.

Test Plan:
- Reset: hold rst=0 for 5 cycles with di_en=1 -> all outputs 0, no do_en. Release, first input re=3, im=4 with SHIFT=0 -> do_en 2 cycles later, data_o=25, idx=0, num=0, is_first_out=1.
- Continuous stream of 1024 bins, re=256, im=0, SHIFT=17 -> sum=65536, data_o=0. With SHIFT=8, data_o=256. Exactly 513 do_en pulses; last has idx=512, is_last_out=1. No do_en for bins 513..1023.
- Saturation: re=-32768, im=-32768, SHIFT=17 -> sum=2^31, p=16384, data_o=8191. re=32767, im=0, SHIFT=17 -> data_o=8191 (p=8191 exactly).
- Gapped input: di_en toggling 1,0,1,0 over bins 0..3 -> do_en pattern identical, delayed 2 cycles; idx values 0,1,2,3 in order.
- Frame wrap: drive 89 full frames -> out_group_num steps 0..88. all_done pulses once, with frame 88 bin 512. The next frame outputs num=0.
- Mid-frame reset: assert rst=0 at bin 300 of frame 2 -> in-flight outputs suppressed. After release the first output has idx=0, num=0.

Source files
------------

// File: rtl/power_spectrum.sv
// power_spectrum: squared magnitude of the non-redundant FFT bins,
// scaled, saturated and tagged with bin/frame position for the log stage.
module power_spectrum #(
  parameter int I_BW    = 16,
  parameter int O_BW    = 14,
  parameter int N_FFT   = 1024,
  parameter int N_BIN   = 513,
  parameter int N_FRAME = 89,
  parameter int SHIFT   = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [I_BW-1:0] data_re_i,
  input  logic [I_BW-1:0] data_im_i,
  input  logic            di_en,
  output logic [O_BW-1:0] data_o,
  output logic            do_en,
  output logic [9:0]      out_group_idx,
  output logic [6:0]      out_group_num,
  output logic            is_first_out,
  output logic            is_last_out,
  output logic            all_done
);

  localparam int BW = $clog2(N_FFT);
  localparam int PW = 2 * I_BW;

  localparam logic [BW-1:0] BIN_END  = BW'(N_FFT - 1);
  localparam logic [BW-1:0] BIN_LAST = BW'(N_BIN - 1);
  localparam logic [6:0]    FR_LAST  = 7'(N_FRAME - 1);
  localparam logic [PW-1:0] P_MAX    = PW'((1 << (O_BW - 1)) - 1);

  logic [BW-1:0] bin_cnt;
  logic [6:0]    frm_cnt;
  logic          acc;

  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic signed [PW-1:0] sq_re_n;
  logic signed [PW-1:0] sq_im_n;

  logic [PW-1:0] sq_re;
  logic [PW-1:0] sq_im;
  logic [PW-1:0] sum;
  logic [PW-1:0] p;
  logic [O_BW-1:0] sat;

  logic [BW-1:0] idx1;
  logic [6:0]    num1;
  logic          first1;
  logic          last1;
  logic          v1;

  // Bins above N_BIN mirror the lower half and only advance the counter.
  assign acc = di_en && (bin_cnt <= BIN_LAST);

  always_comb begin
    re_x    = {{I_BW{data_re_i[I_BW-1]}}, data_re_i};
    im_x    = {{I_BW{data_im_i[I_BW-1]}}, data_im_i};
    sq_re_n = re_x * re_x;
    sq_im_n = im_x * im_x;
    sum     = sq_re + sq_im;
    p       = sum >> SHIFT;
    sat     = (p > P_MAX) ? P_MAX[O_BW-1:0] : p[O_BW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_cnt <= '0;
      frm_cnt <= '0;
      v1      <= 1'b0;
      sq_re   <= '0;
      sq_im   <= '0;
      idx1    <= '0;
      num1    <= '0;
      first1  <= 1'b0;
      last1   <= 1'b0;
    end else begin
      v1 <= acc;
      if (di_en) begin
        if (bin_cnt == BIN_END) begin
          bin_cnt <= '0;
          frm_cnt <= (frm_cnt == FR_LAST) ? 7'd0 : frm_cnt + 7'd1;
        end else begin
          bin_cnt <= bin_cnt + BW'(1);
        end
      end
      if (acc) begin
        sq_re  <= $unsigned(sq_re_n);
        sq_im  <= $unsigned(sq_im_n);
        idx1   <= bin_cnt;
        num1   <= frm_cnt;
        first1 <= (bin_cnt == '0);
        last1  <= (bin_cnt == BIN_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o        <= '0;
      do_en         <= 1'b0;
      out_group_idx <= '0;
      out_group_num <= '0;
      is_first_out  <= 1'b0;
      is_last_out   <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      do_en    <= v1;
      all_done <= v1 && last1 && (num1 == FR_LAST);
      if (v1) begin
        data_o        <= sat;
        out_group_idx <= 10'(idx1);
        out_group_num <= num1;
        is_first_out  <= first1;
        is_last_out   <= last1;
      end
    end
  end

endmodule

// File: tb/tb_power_spectrum.sv
// Directed bench for power_spectrum: vector table plus
// stream, frame-wrap and mid-frame reset sequences.
module tb_power_spectrum;

  localparam int W  = 16;
  localparam int OW = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] re = '0;
  logic [W-1:0] im = '0;
  logic di_en = 1'b0;

  always #5 clk = ~clk;

  logic [OW-1:0] a_d, b_d, c_d, s_d;
  logic a_en, b_en, c_en, s_en;
  logic [9:0] a_idx, b_idx, c_idx, s_idx;
  logic [6:0] a_num, b_num, c_num, s_num;
  logic a_f, b_f, c_f, s_f;
  logic a_l, b_l, c_l, s_l;
  logic a_dn, b_dn, c_dn, s_dn;

  power_spectrum #(.SHIFT(17)) u_a (
    .clk(clk), .rst(rst), .data_re_i(re), .data_im_i(im),
    .di_en(di_en), .data_o(a_d), .do_en(a_en),
    .out_group_idx(a_idx), .out_group_num(a_num),
    .is_first_out(a_f), .is_last_out(a_l), .all_done(a_dn));

  power_spectrum #(.SHIFT(8)) u_b (
    .clk(clk), .rst(rst), .data_re_i(re), .data_im_i(im),
    .di_en(di_en), .data_o(b_d), .do_en(b_en),
    .out_group_idx(b_idx), .out_group_num(b_num),
    .is_first_out(b_f), .is_last_out(b_l), .all_done(b_dn));

  power_spectrum #(.SHIFT(0)) u_c (
    .clk(clk), .rst(rst), .data_re_i(re), .data_im_i(im),
    .di_en(di_en), .data_o(c_d), .do_en(c_en),
    .out_group_idx(c_idx), .out_group_num(c_num),
    .is_first_out(c_f), .is_last_out(c_l), .all_done(c_dn));

  // Small geometry so that a full utterance wrap fits in a short run.
  power_spectrum #(.N_FFT(16), .N_BIN(9), .N_FRAME(5), .SHIFT(0)) u_s (
    .clk(clk), .rst(rst), .data_re_i(re), .data_im_i(im),
    .di_en(di_en), .data_o(s_d), .do_en(s_en),
    .out_group_idx(s_idx), .out_group_num(s_num),
    .is_first_out(s_f), .is_last_out(s_l), .all_done(s_dn));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drv(input bit en, input int r, input int i);
    di_en = en;
    re    = r[W-1:0];
    im    = i[W-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit en;
    int re;
    int im;
    int e17;
    int e8;
    int e0;
  } vec_t;

  vec_t tbl[12];
  vec_t v;
  int k, cnt, fcnt, sb, sf, dn_cnt;

  initial begin
    tbl[0]  = '{1, 3, 4, 0, 0, 25};
    tbl[1]  = '{0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, -32768, -32768, 8191, 8191, 8191};
    tbl[3]  = '{1, 32767, 0, 8191, 8191, 8191};
    tbl[4]  = '{0, 5, 5, 0, 0, 0};
    tbl[5]  = '{1, 256, 0, 0, 256, 8191};
    tbl[6]  = '{1, 0, -300, 0, 351, 8191};
    tbl[7]  = '{1, 1000, 1000, 15, 7812, 8191};
    tbl[8]  = '{1, -1, 1, 0, 0, 2};
    tbl[9]  = '{1, 90, -5, 0, 31, 8125};
    tbl[10] = '{1, 362, 0, 0, 511, 8191};
    tbl[11] = '{1, 363, 0, 1, 514, 8191};

    // Reset held with di_en high: everything stays zero.
    rst = 1'b0;
    drv(1, 7, 7);
    repeat (5) @(negedge clk);
    chk("rst_do_en", a_en, 0);
    chk("rst_data", a_d, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_num", a_num, 0);
    chk("rst_first", a_f, 0);
    chk("rst_last", a_l, 0);
    chk("rst_done", a_dn, 0);
    rst = 1'b1;
    drv(0, 0, 0);

    // Vector table: output for entry i appears two cycles later.
    k = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        v = tbl[i-2];
        chk("tbl_do_en", a_en, v.en);
        chk("tbl_do_en_c", c_en, v.en);
        if (v.en) begin
          chk("tbl_d_sh17", a_d, v.e17);
          chk("tbl_d_sh8", b_d, v.e8);
          chk("tbl_d_sh0", c_d, v.e0);
          chk("tbl_idx", a_idx, k);
          chk("tbl_num", a_num, 0);
          chk("tbl_first", a_f, (k == 0));
          chk("tbl_last", a_l, 0);
          k++;
        end
      end
      if (i < 12) drv(tbl[i].en, tbl[i].re, tbl[i].im);
      else drv(0, 0, 0);
    end

    // One full frame: only bins 0..512 produce output.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 1027; i++) begin
      @(negedge clk);
      if (a_en) begin
        chk("strm_idx", a_idx, cnt);
        chk("strm_d_sh8", b_d, 256);
        if (cnt == 0 || cnt >= 511) begin
          chk("strm_d_sh17", a_d, 0);
          chk("strm_last", a_l, (cnt == 512));
          chk("strm_first", a_f, (cnt == 0));
        end
        cnt++;
      end
      if (i < 1024) drv(1, 256, 0);
      else drv(0, 0, 0);
    end
    chk("strm_count", cnt, 513);

    // Utterance wrap on the small instance: 6 frames of 16 bins.
    do_reset();
    sb = 0;
    sf = 0;
    cnt = 0;
    dn_cnt = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (s_dn) dn_cnt++;
      if (s_en) begin
        chk("wrap_idx", s_idx, sb);
        chk("wrap_num", s_num, sf);
        chk("wrap_first", s_f, (sb == 0));
        chk("wrap_last", s_l, (sb == 8));
        chk("wrap_done", s_dn, (sb == 8 && sf == 4));
        chk("wrap_data", s_d, 4);
        cnt++;
        sb++;
        if (sb == 9) begin
          sb = 0;
          sf = (sf == 4) ? 0 : sf + 1;
        end
      end
      if (i < 96) drv(1, 2, 0);
      else drv(0, 0, 0);
    end
    chk("wrap_count", cnt, 54);
    chk("wrap_done_count", dn_cnt, 1);

    // Frames 0..2 on the full-size instance, reset at bin 300 of frame 2.
    do_reset();
    fcnt = 0;
    for (int i = 0; i < 2348; i++) begin
      @(negedge clk);
      if (a_en && a_idx == 0) begin
        chk("mid_num", a_num, fcnt);
        fcnt++;
      end
      drv(1, 1, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drv(1, 9, 9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_do_en", a_en, 0);
    end
    chk("mid_frames", fcnt, 3);
    rst = 1'b1;
    drv(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_flush", c_en, 0);
    end
    drv(1, 3, 4);
    @(negedge clk);
    drv(0, 0, 0);
    @(negedge clk);
    chk("mid_do_en", c_en, 1);
    chk("mid_data", c_d, 25);
    chk("mid_idx", c_idx, 0);
    chk("mid_num0", c_num, 0);
    chk("mid_first", c_f, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
